if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queued fetch entries; SHALL be a power of two and at least 2.
REQ-002 Parameter LENGTH, default 32, width of the pc and instruction fields.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  branch_taken from the execute path; discards all queued entries.
REQ-006 in_valid  input  1  the fetch stage presents a fetched word this cycle.
REQ-007 pc_in  input  LENGTH  pc+4 value of the fetched word.
REQ-008 instruction_in  input  LENGTH  fetched instruction.
REQ-009 id_freeze  input  1  the decode stage stalls (hazard); head entry SHALL NOT be consumed.
REQ-010 full  output  1  queue holds DEPTH entries; drives the fetch-stage freeze input.
REQ-011 valid_out  output  1  head entry is present.
REQ-012 pc_out  output  LENGTH  pc field of the head entry.
REQ-013 instruction_out  output  LENGTH  instruction field of the head entry.
REQ-014 count  output  clog2(DEPTH+1)  number of occupied entries.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH {pc, instruction} pairs, with a write pointer, a read pointer and an occupancy counter.
REQ-016 pop SHALL equal valid_out AND NOT id_freeze; push SHALL equal in_valid AND (NOT full OR pop).
REQ-017 Outputs are show-ahead: pc_out and instruction_out SHALL reflect the head entry combinationally from registered state, with zero added latency.
REQ-018 An entry pushed in cycle N SHALL appear at the head no earlier than cycle N+1, so there is no combinational bypass from input to output.
REQ-019 When count is 0, valid_out SHALL be 0 and pc_out and instruction_out SHALL be 0, giving a NOP bubble to decode.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged, including when full and when count is 1.
REQ-021 Push when full without a pop SHALL be ignored: no pointer or count change, and data is dropped.
REQ-022 Pop when empty SHALL be impossible, because pop requires valid_out.
REQ-023 Pointers SHALL wrap modulo DEPTH; count SHALL saturate in the range 0..DEPTH and never over- or underflow.
REQ-024 full SHALL be 1 exactly when count equals DEPTH, and SHALL be derived from registered state only.
REQ-025 flush SHALL have highest priority: the next state is count 0 with pointers equal, and any same-cycle push or pop is discarded.
REQ-026 After a flush, valid_out SHALL be 0 in the next cycle; the first post-flush push SHALL become visible one cycle later.
REQ-027 Entry order SHALL be preserved (FIFO); no entry SHALL be duplicated or skipped across wrap-around.

Reset
REQ-028 rst low SHALL asynchronously clear the pointers and count, independent of clk.
REQ-029 Outputs during reset SHALL be: valid_out 0, full 0, count 0, pc_out 0, instruction_out 0.
REQ-030 Storage array contents need not be reset; they SHALL be masked by the REQ-019 behaviour.
REQ-031 Reset asserted mid-operation SHALL drop all entries; the first push after release is the head.

Structure
REQ-032 The DEPTH and LENGTH defaults and the NOP encoding (32'b0) SHALL live in the shared core package, which is also used by the fetch and decode stages.
REQ-033 One sub-module SHALL be used: queue_ram, a DEPTH x (2*LENGTH) register array with one write port and one asynchronous read port. Control logic SHALL stay in if_id_queue.

Verification
REQ-034 Reset, then push pc 4/8/12 with instructions A/B/C and id_freeze 0 -> outputs (4,A), (8,B), (12,C) on consecutive cycles; count never exceeds 1.
REQ-035 Hold id_freeze 1 and push 5 words -> count reaches 4, full rises after the 4th push, the 5th word is dropped, and the head stays at the 1st word.
REQ-036 At full, release id_freeze while in_valid is held -> count stays at 4 for 3 cycles and output order is exact.
REQ-037 With 3 entries queued, assert flush together with in_valid -> next cycle count is 0 and valid_out is 0; a push in the following cycle appears one cycle later as the head.
REQ-038 Assert rst low asynchronously between clock edges with 2 entries queued -> valid_out, count and full go to 0 immediately; after release, a push of (0x100, D) is the head.
REQ-039 Run 1000 random cycles of in_valid, id_freeze and flush against a queue scoreboard -> no mismatch in order, count or full.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared core definitions for the fetch/decode boundary: default queue geometry
// and the NOP encoding handed to decode when no fetched word is available.
package if_id_queue_pkg;

   localparam int QUEUE_DEPTH = 4;
   localparam int INSTR_LENGTH = 32;
   localparam logic [31:0] NOP = 32'b0;

endpackage

// File: rtl/queue_ram.sv
// Register array holding {pc, instruction} pairs: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module queue_ram #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// Show-ahead circular queue between fetch and decode; flush discards all entries
// and an empty queue presents a NOP bubble with valid_out low.
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int DEPTH  = QUEUE_DEPTH,
   parameter int LENGTH = INSTR_LENGTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [LENGTH-1:0]          pc_in,
   input  logic [LENGTH-1:0]          instruction_in,
   input  logic                       id_freeze,
   output logic                       full,
   output logic                       valid_out,
   output logic [LENGTH-1:0]          pc_out,
   output logic [LENGTH-1:0]          instruction_out,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("if_id_queue: DEPTH must be a power of two and at least 2");
   end

   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    occ;
   logic                push;
   logic                pop;
   logic [2*LENGTH-1:0] head;

   // Everything below depends only on registered state plus the handshake inputs
   assign valid_out = (occ != '0);
   assign full      = (occ == FULL_CNT);
   assign count     = occ;
   assign pop       = valid_out & ~id_freeze;
   assign push      = in_valid & (~full | pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   queue_ram #(
      .DEPTH (DEPTH),
      .WIDTH (2 * LENGTH)
   ) u_ram (
      .clk     (clk),
      .we      (push & ~flush),
      .wr_addr (wr_ptr),
      .wr_data ({pc_in, instruction_in}),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

   // Stale array contents are masked so decode sees a clean bubble
   assign pc_out          = valid_out ? head[2*LENGTH-1:LENGTH] : LENGTH'(NOP);
   assign instruction_out = valid_out ? head[LENGTH-1:0]        : LENGTH'(NOP);

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized and directed bench for if_id_queue against a queue-based reference.
module tb_if_id_queue;

   localparam int DEPTH  = 4;
   localparam int LENGTH = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic [LENGTH-1:0] pc_in;
   logic [LENGTH-1:0] instruction_in;
   logic              id_freeze;
   logic              full;
   logic              valid_out;
   logic [LENGTH-1:0] pc_out;
   logic [LENGTH-1:0] instruction_out;
   logic [2:0]        count;

   int total = 0;
   int bad   = 0;
   logic [63:0] model_q[$];
   int max_cnt;

   if_id_queue #(.DEPTH(DEPTH), .LENGTH(LENGTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .in_valid        (in_valid),
      .pc_in           (pc_in),
      .instruction_in  (instruction_in),
      .id_freeze       (id_freeze),
      .full            (full),
      .valid_out       (valid_out),
      .pc_out          (pc_out),
      .instruction_out (instruction_out),
      .count           (count)
   );

   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [63:0] hd;
      hd = (model_q.size() > 0) ? model_q[0] : 64'h0;
      chk_val({tag, ".count"}, 64'(count), 64'(model_q.size()));
      chk_val({tag, ".valid"}, 64'(valid_out), 64'(model_q.size() > 0));
      chk_val({tag, ".full"}, 64'(full), 64'(model_q.size() == DEPTH));
      chk_val({tag, ".pc"}, 64'(pc_out), 64'(hd[63:32]));
      chk_val({tag, ".instr"}, 64'(instruction_out), 64'(hd[31:0]));
   endtask

   // Drive one cycle of inputs, advance the reference, then compare after the edge
   task automatic step(input string tag, input logic f, input logic iv, input logic fr,
                       input logic [31:0] pc, input logic [31:0] ins);
      bit do_pop, do_push;
      flush = f; in_valid = iv; id_freeze = fr; pc_in = pc; instruction_in = ins;
      if (f) begin
         model_q.delete();
      end else begin
         do_pop  = (model_q.size() > 0) && !fr;
         do_push = iv && ((model_q.size() < DEPTH) || do_pop);
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back({pc, ins});
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
      if (int'(count) > max_cnt) max_cnt = int'(count);
   endtask

   task automatic idle(input string tag, input logic fr);
      step(tag, 1'b0, 1'b0, fr, 32'h0, 32'h0);
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; id_freeze = 1'b0;
      pc_in = '0; instruction_in = '0;
      #2;
      check_outputs("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // streaming with no stall
      max_cnt = 0;
      step("seq1", 0, 1, 0, 32'd4,  32'h0000_000A);
      step("seq2", 0, 1, 0, 32'd8,  32'h0000_000B);
      step("seq3", 0, 1, 0, 32'd12, 32'h0000_000C);
      idle("seq_drain", 0);
      chk_val("seq_maxcount", 64'(max_cnt), 64'd1);

      // stall fills the queue, fifth word dropped
      for (int i = 0; i < 5; i++)
         step("fill", 0, 1, 1, 32'h20 + 32'(i * 4), 32'hF000_0000 + 32'(i));
      chk_val("fill_head", 64'(pc_out), 64'h20);

      // release stall with input held: count stays at DEPTH
      for (int i = 0; i < 3; i++)
         step("stream_full", 0, 1, 0, 32'h40 + 32'(i * 4), 32'hE000_0000 + 32'(i));
      for (int i = 0; i < DEPTH; i++) idle("drain", 0);

      // flush with a same-cycle push
      for (int i = 0; i < 3; i++)
         step("pre_flush", 0, 1, 1, 32'h80 + 32'(i * 4), 32'hD000_0000 + 32'(i));
      step("flush", 1, 1, 0, 32'hBAD, 32'hBAD);
      step("post_flush_push", 0, 1, 1, 32'h90, 32'h0000_0090);
      idle("post_flush_hold", 1);
      idle("post_flush_drain", 0);

      // asynchronous reset between edges
      step("pre_rst", 0, 1, 1, 32'hA0, 32'h0000_00A0);
      step("pre_rst", 0, 1, 1, 32'hA4, 32'h0000_00A4);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      model_q.delete();
      #1 check_outputs("async_rst");
      #2 rst = 1'b1;
      step("rst_push", 0, 1, 1, 32'h100, 32'h0000_000D);
      idle("rst_head", 1);
      idle("rst_drain", 0);

      // random traffic
      for (int i = 0; i < 1000; i++) begin
         logic f, iv, fr;
         f  = ($urandom_range(0, 15) == 0);
         iv = ($urandom_range(0, 3) != 0);
         fr = ($urandom_range(0, 1) == 1);
         step("rand", f, iv, fr, 32'($urandom), 32'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
